// File: rtl/filter_scan_sequencer.sv
// Walks a latched filter mask in group-major order and streams the index of every set bit.
// Build macro FILTER_SCAN_GROUP_SKIP_EN enables skipping an all-zero group in a single cycle.
module filter_scan_sequencer #(
  parameter int WIDTH = 32,
  parameter int GROUP = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] start_mask,
  input  logic             start_invert,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic [IDX_W:0]   emit_count
);

  localparam int GROUPS = WIDTH / GROUP;
  localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int LANE_W = $clog2(GROUP);
  localparam int CNT_W  = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  mask_q, mask_d;
  logic [GRP_W-1:0]  group_q, group_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [CNT_W-1:0]  emit_count_q, emit_count_d;

  logic [IDX_W-1:0]  pos;
  logic [WIDTH-1:0]  above;
  logic              bit_set;
  logic              advance;
  logic              last_lane;
  logic              last_group;

  // Mask shifted so bit 0 is the current position; the rest are the bits still ahead.
  assign pos        = IDX_W'(group_q) * IDX_W'(GROUP) + IDX_W'(lane_q);
  assign above      = mask_q >> pos;
  assign bit_set    = above[0];
  assign advance    = !bit_set || out_ready;
  assign last_lane  = (lane_q == LANE_W'(GROUP - 1));
  assign last_group = (group_q == GRP_W'(GROUPS - 1));

`ifdef FILTER_SCAN_GROUP_SKIP_EN
  logic group_empty;
  assign group_empty = (lane_q == '0) && (above[GROUP-1:0] == '0);
`endif

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign out_valid   = (state_q == SCAN) && bit_set;
  assign out_index   = pos;
  assign out_last    = out_valid && (above[WIDTH-1:1] == '0);
  assign emit_count  = emit_count_q;

  always_comb begin
    // NOTE: every _d defaults to its _q first so no path through the case infers a latch.
    state_d      = state_q;
    mask_d       = mask_q;
    group_d      = group_q;
    lane_d       = lane_q;
    emit_count_d = emit_count_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          mask_d       = start_invert ? ~start_mask : start_mask;
          group_d      = '0;
          lane_d       = '0;
          emit_count_d = '0;
          state_d      = SCAN;
        end
      end
      SCAN: begin
        if (out_valid && out_ready) begin
          emit_count_d = emit_count_q + CNT_W'(1);
        end
`ifdef FILTER_SCAN_GROUP_SKIP_EN
        if (group_empty) begin
          group_d = last_group ? '0 : group_q + GRP_W'(1);
          if (last_group) state_d = DONE;
        end else
`endif
        if (advance) begin
          if (last_lane) begin
            lane_d  = '0;
            group_d = last_group ? '0 : group_q + GRP_W'(1);
            if (last_group) state_d = DONE;
          end else begin
            lane_d = lane_q + LANE_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the same pre-edge values.
    if (rst) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      group_q      <= '0;
      lane_q       <= '0;
      emit_count_q <= '0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      group_q      <= group_d;
      lane_q       <= lane_d;
      emit_count_q <= emit_count_d;
    end
  end

endmodule

// File: tb/tb_filter_scan_sequencer.sv
// Self-checking bench for filter_scan_sequencer: directed and random commands checked
// against a queue-based model of the expected index stream and scan length.
module tb_filter_scan_sequencer;

  localparam int WIDTH = 32;
  localparam int GROUP = 8;
  localparam int IDX_W = $clog2(WIDTH);

  logic             clk = 1'b0;
  logic             rst;
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] start_mask;
  logic             start_invert;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_index;
  logic             out_last;
  logic             busy;
  logic             done;
  logic [IDX_W:0]   emit_count;

  int checks   = 0;
  int failures = 0;

  filter_scan_sequencer #(.WIDTH(WIDTH), .GROUP(GROUP), .IDX_W(IDX_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .start_mask   (start_mask),
    .start_invert (start_invert),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_index    (out_index),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done),
    .emit_count   (emit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scan length in cycles, excluding stalls: one per position, or one per empty group when skipping.
  function automatic int model_scan_cycles(input logic [WIDTH-1:0] m);
    int n = 0;
    int p = 0;
    while (p < WIDTH) begin
      n++;
`ifdef FILTER_SCAN_GROUP_SKIP_EN
      if ((p % GROUP == 0) && (m[p +: GROUP] == '0)) p += GROUP;
      else p++;
`else
      p++;
`endif
    end
    return n;
  endfunction

  task automatic run_cmd(input logic [WIDTH-1:0] m, input logic inv, input int stall_idx,
                         input int stall_len, input bit rand_ready, input bit poke);
    logic [WIDTH-1:0] eff;
    int exp_q[$];
    int last_idx  = -1;
    int scan      = 0;
    int stalls    = 0;
    int accepted  = 0;
    int cyc       = 0;
    int stall_left;
    bit seen_done = 0;
    eff = inv ? ~m : m;
    for (int p = 0; p < WIDTH; p++) begin
      if (eff[p]) begin
        exp_q.push_back(p);
        last_idx = p;
      end
    end
    stall_left = stall_len;

    check("idle_start_ready", start_ready, 1);
    start_mask   = m;
    start_invert = inv;
    start_valid  = 1'b1;
    tick();
    start_valid  = 1'b0;

    while (!seen_done && cyc < 500) begin
      cyc++;
      start_valid = 1'b0;
      if (done) begin
        seen_done = 1;
      end else begin
        scan++;
        if (poke && cyc == 5) begin
          start_valid  = 1'b1;
          start_mask   = ~eff;
          start_invert = 1'b0;
          check("start_ready_busy", start_ready, 0);
          check("busy_in_scan", busy, 1);
        end
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_valid", out_valid, 0);
            out_ready = 1'b1;
          end else begin
            check("out_index", out_index, exp_q[0]);
            check("out_last", out_last, exp_q[0] == last_idx);
            if (exp_q[0] == stall_idx && stall_left > 0) begin
              out_ready = 1'b0;
              stall_left--;
              stalls++;
            end else if (rand_ready && $urandom_range(3) == 0) begin
              out_ready = 1'b0;
              stalls++;
            end else begin
              out_ready = 1'b1;
              void'(exp_q.pop_front());
              accepted++;
            end
          end
        end else begin
          out_ready = 1'($urandom_range(1));
        end
      end
      tick();
    end

    start_valid = 1'b0;
    check("done_seen", seen_done, 1);
    check("all_indices_emitted", exp_q.size(), 0);
    check("scan_cycles", scan, model_scan_cycles(eff) + stalls);
    check("emit_count", emit_count, accepted);
    check("done_one_cycle", done, 0);
    check("ready_after_done", start_ready, 1);
  endtask

  initial begin
    int guard;
    int done_pulses;
    rst          = 1'b1;
    start_valid  = 1'b0;
    start_mask   = '0;
    start_invert = 1'b0;
    out_ready    = 1'b0;
    repeat (3) tick();
    check("rst_start_ready", start_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_emit_count", emit_count, 0);
    rst = 1'b0;
    tick();

    run_cmd(32'h0000_0001, 1'b0, -1, 0, 1'b0, 1'b0);
    run_cmd(32'hAAAA_AAAA, 1'b1, -1, 0, 1'b0, 1'b0);
    run_cmd(32'h8000_0100, 1'b0, 8, 5, 1'b0, 1'b0);
    run_cmd(32'h0000_0000, 1'b0, -1, 0, 1'b0, 1'b0);
    run_cmd(32'h8000_0000, 1'b0, -1, 0, 1'b0, 1'b0);
    run_cmd(32'h00F0_0F01, 1'b0, -1, 0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      run_cmd($urandom, 1'($urandom_range(1)), -1, 0, 1'b1, i[0]);
    end

    // Reset while stalled on index 8: command discarded, no done pulse.
    start_mask   = 32'h8000_0100;
    start_invert = 1'b0;
    start_valid  = 1'b1;
    out_ready    = 1'b0;
    tick();
    start_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 50) begin
      guard++;
      tick();
    end
    check("stall_valid_before_rst", out_valid, 1);
    check("stall_index_before_rst", out_index, 8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_emit_count", emit_count, 0);
    check("mid_rst_start_ready", start_ready, 1);
    done_pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_pulses++;
      tick();
    end
    check("mid_rst_no_done", done_pulses, 0);
    check("mid_rst_still_idle", busy, 0);

    run_cmd(32'h0100_0010, 1'b0, -1, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
